// File: rtl/fifo_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_ctrl_if
// Description : Producer/consumer handshake bundle for fifo_arb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_arb_ctrl_if #(
    parameter int BITS  = 4,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            req0;
    logic            req1;
    logic [BITS-1:0] data0;
    logic [BITS-1:0] data1;
    logic            pop;
    logic            drain;
    logic            clr;
    logic            gnt0;
    logic            gnt1;
    logic            push_en;
    logic [BITS-1:0] push_data;
    logic [CW-1:0]   sel;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            pop_ok;
    logic            draining;
    logic            underflow;

    modport master (
        output req0, req1, data0, data1, pop, drain, clr,
        input  gnt0, gnt1, push_en, push_data, sel, count,
        input  full, empty, pop_ok, draining, underflow
    );

    modport slave (
        input  req0, req1, data0, data1, pop, drain, clr,
        output gnt0, gnt1, push_en, push_data, sel, count,
        output full, empty, pop_ok, draining, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_ctrl
// Description : Round-robin two-producer arbiter and occupancy/drain control
//               for a shift-register FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_arb_ctrl #(
    parameter int BITS  = 4,
    parameter int DEPTH = 8
) (
    input  wire            clk,
    input  wire            rst_n,
    fifo_arb_ctrl_if.slave bus
);
    localparam int c_CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_count;
    logic [c_CW-1:0]   w_count_nxt;
    logic              r_last;
    logic              r_drain_q;
    logic              r_underflow;
    logic              w_empty;
    logic              w_full;
    logic              w_drain_rise;
    logic              w_pop_ok;
    logic              w_eligible;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_push_en;
    logic [BITS-1:0]   w_push_data;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == c_CW'(DEPTH));
    assign w_drain_rise = bus.drain & ~r_drain_q;

    always_comb begin
        w_state_nxt = r_state;
        w_pop_ok    = 1'b0;
        w_eligible  = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_pop_ok   = bus.pop & ~w_empty;
                // A full FIFO still accepts a push when a pop frees a slot this cycle.
                w_eligible = ~w_full | w_pop_ok;
                if (w_eligible) begin
                    if (bus.req0 && bus.req1) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = bus.req0;
                        w_gnt1 = bus.req1;
                    end
                end
                if (w_drain_rise && !w_empty)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_pop_ok = 1'b1;
                if (r_count <= c_CW'(1))
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    assign w_push_en   = w_gnt0 | w_gnt1;
    assign w_push_data = w_gnt0 ? bus.data0 : (w_gnt1 ? bus.data1 : '0);
    assign w_count_nxt = r_count + {{(c_CW-1){1'b0}}, w_push_en}
                                 - {{(c_CW-1){1'b0}}, w_pop_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_count     <= '0;
            r_last      <= 1'b1;
            r_drain_q   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_drain_q <= bus.drain;
            if (w_push_en)
                r_last <= w_gnt1;
            if (bus.clr)
                r_underflow <= 1'b0;
            else if (r_state == S_RUN && bus.pop && w_empty)
                r_underflow <= 1'b1;
        end
    end

    assign bus.gnt0      = w_gnt0;
    assign bus.gnt1      = w_gnt1;
    assign bus.push_en   = w_push_en;
    assign bus.push_data = w_push_data;
    assign bus.sel       = r_count;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.pop_ok    = w_pop_ok;
    assign bus.draining  = (r_state == S_DRAIN);
    assign bus.underflow = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fifo_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_arb_ctrl
// Description : Directed self-checking bench for fifo_arb_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_arb_ctrl;
    localparam int c_BITS  = 4;
    localparam int c_DEPTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fifo_arb_ctrl_if #(.BITS(c_BITS), .DEPTH(c_DEPTH)) bus ();

    fifo_arb_ctrl #(.BITS(c_BITS), .DEPTH(c_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
        bus.pop = 0; bus.drain = 0; bus.clr = 0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_underflow", 32'(bus.underflow), 0);
        chk("rst_draining", 32'(bus.draining), 0);

        // Round-robin between two held requesters: A,5,A,5
        tick();
        bus.req0 = 1; bus.req1 = 1; bus.data0 = 4'hA; bus.data1 = 4'h5;
        #1;
        chk("rr0_gnt0", 32'(bus.gnt0), 1);
        chk("rr0_data", 32'(bus.push_data), 32'hA);
        tick(); #1;
        chk("rr1_gnt1", 32'(bus.gnt1), 1);
        chk("rr1_data", 32'(bus.push_data), 32'h5);
        tick(); #1;
        chk("rr2_gnt0", 32'(bus.gnt0), 1);
        chk("rr2_data", 32'(bus.push_data), 32'hA);
        tick(); #1;
        chk("rr3_gnt1", 32'(bus.gnt1), 1);
        chk("rr3_data", 32'(bus.push_data), 32'h5);
        tick();
        bus.req0 = 0; bus.req1 = 0;
        #1;
        chk("rr_count", 32'(bus.count), 4);
        chk("idle_push_data", 32'(bus.push_data), 0);
        chk("idle_push_en", 32'(bus.push_en), 0);

        // Fill to depth with requester 0
        bus.req0 = 1;
        repeat (4) tick();
        #1;
        chk("full_count", 32'(bus.count), 8);
        chk("full_flag", 32'(bus.full), 1);
        chk("full_sel", 32'(bus.sel), 8);
        chk("full_gnt0_blocked", 32'(bus.gnt0), 0);
        bus.pop = 1;
        #1;
        chk("full_pop_gnt0", 32'(bus.gnt0), 1);
        chk("full_pop_ok", 32'(bus.pop_ok), 1);
        tick();
        bus.req0 = 0;
        #1;
        chk("full_pushpop_count", 32'(bus.count), 8);
        repeat (8) tick();
        bus.pop = 0;
        #1;
        chk("popped_count", 32'(bus.count), 0);
        chk("popped_empty", 32'(bus.empty), 1);

        // Underflow is sticky until clr
        bus.pop = 1;
        #1;
        chk("uf_pop_ok", 32'(bus.pop_ok), 0);
        tick();
        bus.pop = 0;
        #1;
        chk("uf_set", 32'(bus.underflow), 1);
        tick(); #1;
        chk("uf_sticky", 32'(bus.underflow), 1);
        chk("uf_count", 32'(bus.count), 0);
        bus.clr = 1;
        tick();
        bus.clr = 0;
        #1;
        chk("uf_clr", 32'(bus.underflow), 0);

        // Drain of 5 entries while requester 1 waits
        bus.req0 = 1; bus.data0 = 4'h3;
        repeat (5) tick();
        bus.req0 = 0;
        #1;
        chk("pre_drain_count", 32'(bus.count), 5);
        bus.drain = 1;
        #1;
        chk("drain_edge_run", 32'(bus.draining), 0);
        tick();
        bus.req1 = 1; bus.data1 = 4'h9;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("drain_active", 32'(bus.draining), 1);
            chk("drain_gnt1", 32'(bus.gnt1), 0);
            chk("drain_pop_ok", 32'(bus.pop_ok), 1);
            chk("drain_count", 32'(bus.count), 32'(5 - i));
            tick();
        end
        #1;
        chk("drain_done", 32'(bus.draining), 0);
        chk("drain_done_count", 32'(bus.count), 0);
        chk("drain_done_gnt1", 32'(bus.gnt1), 1);
        tick();
        bus.req1 = 0; bus.drain = 0;
        #1;
        chk("post_drain_count", 32'(bus.count), 1);

        // Asynchronous reset mid-drain with count=3
        bus.req0 = 1;
        repeat (2) tick();
        bus.req0 = 0;
        #1;
        chk("pre_rst_count", 32'(bus.count), 3);
        bus.drain = 1;
        tick();
        #1;
        chk("rst_in_drain", 32'(bus.draining), 1);
        chk("rst_in_drain_count", 32'(bus.count), 3);
        bus.drain = 0;
        rst_n = 0;
        #1;
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_draining", 32'(bus.draining), 0);
        tick();
        rst_n = 1;
        bus.req0 = 1; bus.req1 = 1;
        #1;
        chk("post_rst_gnt0", 32'(bus.gnt0), 1);
        chk("post_rst_gnt1", 32'(bus.gnt1), 0);
        tick();
        bus.req0 = 0; bus.req1 = 0;
        #1;
        chk("post_rst_count", 32'(bus.count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
